// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one single-port, word-addressed data memory between
// the CPU (m0) and a DMA/peripheral master (m1).
//  - Round-robin arbitration with a bounded burst of MAX_BURST consecutive grants.
//  - Grant is combinational; the accepted command is registered (memory cycle),
//    and the completion is registered again (ack cycle): req-to-ack latency 2.
//  - Optional build macro MEM_ARB_RANGE_CHECK_EN: adds m0_err/m1_err; accesses at
//    word index >= RAM_SIZE are acknowledged with err=1 and never reach memory.
module data_mem_arbiter #(
  parameter int RAM_SIZE  = 256,
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
`ifdef MEM_ARB_RANGE_CHECK_EN
  output logic        m0_err,
  output logic        m1_err,
`endif
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  // Reject configurations the arbitration rules cannot honour.
  if (MAX_BURST < 1 || RAM_SIZE < 1) begin : g_param_check
    $error("data_mem_arbiter: MAX_BURST and RAM_SIZE must be >= 1");
  end

  // Arbitration decision and the fields of the selected request.
  logic        gnt_any_s;
  logic        sel_s;
  logic        sel_we_s;
  logic        sel_oor_s;
  logic [31:0] sel_addr_s;
  logic [31:0] sel_wdata_s;

  // Arbitration history: who had the last grant and how long the run is.
  logic          last_owner_q, last_owner_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;

  // Command (memory cycle) stage.
  logic        cmd_valid_q, cmd_valid_d;
  logic        cmd_master_q, cmd_master_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  // Response (ack cycle) stage.
  logic        m0_ack_q, m0_ack_d;
  logic        m1_ack_q, m1_ack_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;

`ifdef MEM_ARB_RANGE_CHECK_EN
  localparam logic [29:0] RAM_WORDS = 30'(RAM_SIZE);
  logic cmd_err_q, cmd_err_d;
  logic m0_err_q, m0_err_d;
  logic m1_err_q, m1_err_d;
`endif

  // Pick the winner: a lone requester always wins; on contention the current
  // owner keeps the bus only while its unbroken burst is below MAX_BURST.
  always_comb begin
    gnt_any_s = 1'b0;
    sel_s     = 1'b0;
    case ({m1_req, m0_req})
      2'b01: begin
        gnt_any_s = 1'b1;
        sel_s     = 1'b0;
      end
      2'b10: begin
        gnt_any_s = 1'b1;
        sel_s     = 1'b1;
      end
      2'b11: begin
        gnt_any_s = 1'b1;
        if (burst_cnt_q != {BW{1'b0}} && burst_cnt_q != BURST_MAX) begin
          sel_s = last_owner_q;
        end else begin
          sel_s = ~last_owner_q;
        end
      end
      default: begin
        gnt_any_s = 1'b0;
        sel_s     = 1'b0;
      end
    endcase
  end

  // Route the winning master's command fields.
  always_comb begin
    if (sel_s) begin
      sel_we_s    = m1_we;
      sel_addr_s  = m1_addr;
      sel_wdata_s = m1_wdata;
    end else begin
      sel_we_s    = m0_we;
      sel_addr_s  = m0_addr;
      sel_wdata_s = m0_wdata;
    end
  end

`ifdef MEM_ARB_RANGE_CHECK_EN
  assign sel_oor_s = (sel_addr_s[31:2] >= RAM_WORDS);
`else
  assign sel_oor_s = 1'b0;
`endif

  // Grants are suppressed while reset is asserted since nothing can be captured.
  assign m0_gnt = reset & gnt_any_s & ~sel_s;
  assign m1_gnt = reset & gnt_any_s & sel_s;

  // Track last owner and burst length; an idle cycle ends the burst.
  always_comb begin
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    if (gnt_any_s) begin
      last_owner_d = sel_s;
      if (sel_s == last_owner_q) begin
        if (burst_cnt_q == BURST_MAX) begin
          burst_cnt_d = burst_cnt_q;
        end else begin
          burst_cnt_d = burst_cnt_q + {{(BW-1){1'b0}}, 1'b1};
        end
      end else begin
        burst_cnt_d = {{(BW-1){1'b0}}, 1'b1};
      end
    end else begin
      burst_cnt_d = {BW{1'b0}};
    end
  end

  // Build the memory-cycle command from the granted request.
  always_comb begin
    cmd_valid_d  = gnt_any_s;
    cmd_master_d = sel_s;
    mem_rd_d     = gnt_any_s & ~sel_we_s & ~sel_oor_s;
    mem_wr_d     = gnt_any_s & sel_we_s & ~sel_oor_s;
    if (gnt_any_s) begin
      mem_addr_d  = sel_addr_s & 32'hFFFF_FFFC;
      mem_wdata_d = sel_wdata_s;
    end else begin
      mem_addr_d  = 32'h0000_0000;
      mem_wdata_d = 32'h0000_0000;
    end
`ifdef MEM_ARB_RANGE_CHECK_EN
    cmd_err_d = gnt_any_s & sel_oor_s;
`endif
  end

  // Turn the memory cycle into a per-master completion; read data only for
  // forwarded reads, zero otherwise.
  always_comb begin
    m0_ack_d = cmd_valid_q & ~cmd_master_q;
    m1_ack_d = cmd_valid_q & cmd_master_q;
    if (m0_ack_d && mem_rd_q) begin
      m0_rdata_d = mem_rdata;
    end else begin
      m0_rdata_d = 32'h0000_0000;
    end
    if (m1_ack_d && mem_rd_q) begin
      m1_rdata_d = mem_rdata;
    end else begin
      m1_rdata_d = 32'h0000_0000;
    end
`ifdef MEM_ARB_RANGE_CHECK_EN
    m0_err_d = m0_ack_d & cmd_err_q;
    m1_err_d = m1_ack_d & cmd_err_q;
`endif
  end

  // Arbitration history registers; m1 is the last owner out of reset so m0 wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_owner_q <= 1'b1;
      burst_cnt_q  <= {BW{1'b0}};
    end else begin
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  // Command stage registers; reset drops an in-flight access immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_valid_q  <= 1'b0;
      cmd_master_q <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= 32'h0000_0000;
      mem_wdata_q  <= 32'h0000_0000;
`ifdef MEM_ARB_RANGE_CHECK_EN
      cmd_err_q    <= 1'b0;
`endif
    end else begin
      cmd_valid_q  <= cmd_valid_d;
      cmd_master_q <= cmd_master_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
`ifdef MEM_ARB_RANGE_CHECK_EN
      cmd_err_q    <= cmd_err_d;
`endif
    end
  end

  // Response stage registers driving the ack/rdata(/err) outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_rdata_q <= 32'h0000_0000;
      m1_rdata_q <= 32'h0000_0000;
`ifdef MEM_ARB_RANGE_CHECK_EN
      m0_err_q   <= 1'b0;
      m1_err_q   <= 1'b0;
`endif
    end else begin
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
`ifdef MEM_ARB_RANGE_CHECK_EN
      m0_err_q   <= m0_err_d;
      m1_err_q   <= m1_err_d;
`endif
    end
  end

  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
`ifdef MEM_ARB_RANGE_CHECK_EN
  assign m0_err    = m0_err_q;
  assign m1_err    = m1_err_q;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Testbench for data_mem_arbiter: a transaction-level model (grant history,
// two-slot pipeline, reference memory) checked every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_data_mem_arbiter;
  localparam int MAXB = 4;
`ifdef MEM_ARB_RANGE_CHECK_EN
  localparam bit RNG = 1'b1;
`else
  localparam bit RNG = 1'b0;
`endif

  logic        clk, reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_ack, m1_gnt, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_ARB_RANGE_CHECK_EN
  logic        m0_err, m1_err;
`endif

  data_mem_arbiter #(.RAM_SIZE(256), .MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
`ifdef MEM_ARB_RANGE_CHECK_EN
    .m0_err(m0_err), .m1_err(m1_err),
`endif
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // Attached memory: combinational read, write commits at the clock edge.
  logic [31:0] env_mem [0:255];
  assign mem_rdata = env_mem[mem_addr[9:2]];
  initial begin
    for (int i = 0; i < 256; i++) env_mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (mem_wr === 1'b1) env_mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        v;
    logic        m;
    logic        we;
    logic        err;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } item_t;

  logic [31:0] ref_mem [0:255];
  int    hist[$];          // owner granted each cycle since reset, -1 = idle
  int    glog[$];          // grant log for directed scenarios
  bit    log_en = 1'b0;
  int    ack0_cnt = 0;
  int    ack1_cnt = 0;

  // Arbitration from the rules: lone requester wins; on contention the owner of
  // the most recent unbroken run keeps going until the run reaches MAXB.
  function automatic int arb_pick(input logic r0, input logic r1);
    int lo;
    int run;
    int last;
    lo  = 1;
    run = 0;
    if (!r0 && !r1) return -1;
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != -1) begin
        lo = hist[i];
        break;
      end
    end
    if (hist.size() > 0) begin
      last = hist[hist.size() - 1];
      if (last != -1) begin
        for (int i = hist.size() - 1; i >= 0; i--) begin
          if (hist[i] != last) break;
          run++;
        end
      end
    end
    if (run > 0 && run < MAXB) return lo;
    return 1 - lo;
  endfunction

  // Compare process: every falling edge check grant, memory port and ack port.
  initial begin
    item_t ms, as_, ni;
    int g;
    logic [1:0]  e_ack;
    logic [31:0] e_rd0, e_rd1;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    ms  = '0;
    as_ = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        ms  = '0;
        as_ = '0;
        hist.delete();
      end else begin
        g = arb_pick(m0_req, m1_req);
        chk("gnt", {m1_gnt, m0_gnt}, (g == 0) ? 2'b01 : ((g == 1) ? 2'b10 : 2'b00));
        if (ms.v) begin
          chk("mem_rd", mem_rd, !ms.we && !ms.err);
          chk("mem_wr", mem_wr, ms.we && !ms.err);
          if (!ms.err) begin
            chk("mem_addr", mem_addr, ms.addr & 32'hFFFF_FFFC);
            if (ms.we) begin
              chk("mem_wdata", mem_wdata, ms.wdata);
              ref_mem[ms.addr[9:2]] = ms.wdata;
            end else begin
              ms.rdata = ref_mem[ms.addr[9:2]];
            end
          end
        end else begin
          chk("mem_idle", {mem_rd, mem_wr}, 2'b00);
        end
        e_ack = 2'b00;
        e_rd0 = 32'h0;
        e_rd1 = 32'h0;
        if (as_.v) begin
          e_ack = as_.m ? 2'b10 : 2'b01;
          if (!as_.we && !as_.err) begin
            if (as_.m) e_rd1 = as_.rdata;
            else       e_rd0 = as_.rdata;
          end
        end
        chk("ack", {m1_ack, m0_ack}, e_ack);
        chk("m0_rdata", m0_rdata, e_rd0);
        chk("m1_rdata", m1_rdata, e_rd1);
`ifdef MEM_ARB_RANGE_CHECK_EN
        chk("err", {m1_err, m0_err}, (as_.v && as_.err) ? e_ack : 2'b00);
`endif
        if (m0_ack === 1'b1) ack0_cnt++;
        if (m1_ack === 1'b1) ack1_cnt++;
        as_ = ms;
        ni  = '0;
        if (g >= 0) begin
          ni.v     = 1'b1;
          ni.m     = (g == 1);
          ni.we    = (g == 1) ? m1_we : m0_we;
          ni.addr  = (g == 1) ? m1_addr : m0_addr;
          ni.wdata = (g == 1) ? m1_wdata : m0_wdata;
          ni.err   = RNG && (ni.addr[31:2] >= 30'd256);
          if (log_en) glog.push_back(g);
        end
        ms = ni;
        hist.push_back(g);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int cnt, w, a0;
    logic [11:0] exp_ord, act_ord;
    logic [1:0] pat [0:15];
    pat = '{2'b01, 2'b11, 2'b11, 2'b10, 2'b00, 2'b11, 2'b01, 2'b11,
            2'b11, 2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b11, 2'b11};

    reset = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", {m0_gnt, m1_gnt, m0_ack, m1_ack, mem_rd, mem_wr}, 6'b0);
    chk("reset_data", {m0_rdata, m1_rdata}, 64'h0);
    chk("reset_mem", {mem_addr, mem_wdata}, 64'h0);
    @(posedge clk); #2 reset = 1'b1;

    // write then read back, back-to-back
    @(posedge clk); #1;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0000_0010; m0_wdata = 32'hDEAD_BEEF;
    @(negedge clk); chk("wr_gnt", m0_gnt, 1'b1);
    @(posedge clk); #1;
    m0_we = 1'b0; m0_wdata = 32'h0;
    @(negedge clk); chk("rd_gnt", m0_gnt, 1'b1);
    @(posedge clk); #1;
    m0_req = 1'b0;
    @(negedge clk); chk("wr_ack", {m0_ack, m0_rdata}, {1'b1, 32'h0});
    @(negedge clk); chk("rd_ack", {m0_ack, m0_rdata}, {1'b1, 32'hDEAD_BEEF});

    // both request continuously from reset
    do_reset();
    @(posedge clk); #1;
    glog.delete(); log_en = 1'b1;
    m0_req = 1'b1; m0_addr = 32'h0000_0040;
    m1_req = 1'b1; m1_addr = 32'h0000_0080;
    repeat (12) @(negedge clk);
    @(posedge clk); #1;
    log_en = 1'b0;
    idle_inputs();
    exp_ord = 12'b0000_1111_0000;
    act_ord = 12'h0;
    for (int i = 0; i < 12 && i < glog.size(); i++) act_ord[11-i] = glog[i][0];
    chk("rr_len", glog.size(), 12);
    chk("rr_order", act_ord, exp_ord);
    repeat (3) @(negedge clk);

    // m1 alone for 10 cycles, then m0 joins
    @(posedge clk); #1;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h0000_0100; m1_wdata = 32'h1111_0000;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (m1_gnt === 1'b1) cnt++;
    end
    chk("m1_solo", cnt, 10);
    @(posedge clk); #1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0104;
    w = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (m0_gnt === 1'b1) begin
        w = k;
        break;
      end
    end
    chk("m0_join_wait", w, 1);
    @(posedge clk); #1;
    idle_inputs();
    repeat (3) @(negedge clk);

    // unaligned / out-of-range address
    @(posedge clk); #1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0403;
    @(negedge clk); chk("oor_gnt", m0_gnt, 1'b1);
    @(posedge clk); #1;
    m0_req = 1'b0;
    @(negedge clk);
    chk("oor_addr", mem_addr, 32'h0000_0400);
    chk("oor_rd", mem_rd, !RNG);
    @(negedge clk);
    chk("oor_ack", m0_ack, 1'b1);
`ifdef MEM_ARB_RANGE_CHECK_EN
    chk("oor_err", m0_err, 1'b1);
    chk("oor_rdata", m0_rdata, 32'h0);
`else
    chk("oor_rdata", m0_rdata, 32'hC0DE_0000);
`endif
    repeat (2) @(negedge clk);

    // m0 withdraws before being granted while m1 bursts
    a0 = ack0_cnt;
    @(posedge clk); #1;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0200;
    @(posedge clk); #1;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0000_0030; m0_wdata = 32'hBAD0_BAD0;
    @(negedge clk); chk("drop_gnt", {m0_gnt, m1_gnt}, 2'b01);
    @(posedge clk); #1;
    m0_req = 1'b0;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (m1_gnt === 1'b1) cnt++;
    end
    chk("drop_m1_stream", cnt, 4);
    @(posedge clk); #1;
    idle_inputs();
    repeat (4) @(negedge clk);
    #1;
    chk("drop_no_ack", ack0_cnt - a0, 0);
    chk("drop_mem", env_mem[12], 32'hC0DE_000C);

    // reset in the middle of a write
    @(posedge clk); #1;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0000_0020; m0_wdata = 32'h1234_5678;
    @(negedge clk); chk("rst_gnt", m0_gnt, 1'b1);
    @(posedge clk); #1;
    idle_inputs();
    #1 chk("rst_mw_before", mem_wr, 1'b1);
    reset = 1'b0;
    #1 chk("rst_mw_after", mem_wr, 1'b0);
    cnt = 0;
    repeat (2) begin
      @(negedge clk);
      if (m0_ack !== 1'b0) cnt++;
    end
    @(posedge clk); #2 reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (m0_ack !== 1'b0) cnt++;
    end
    chk("rst_no_ack", cnt, 0);
    chk("rst_mem_word", env_mem[8], 32'hC0DE_0008);

    // mixed traffic from a request-pattern table
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      m0_req   = pat[i][0];
      m0_we    = (i % 2 == 0);
      m0_addr  = 32'h0000_0300 + 32'(i % 4) * 32'd4;
      m0_wdata = 32'hA000_0000 | 32'(i);
      m1_req   = pat[i][1];
      m1_we    = (i % 3 == 0) && (i != 9);
      m1_addr  = (i == 9) ? 32'h0000_0800 : (32'h0000_0300 + 32'((i + 1) % 4) * 32'd4);
      m1_wdata = 32'hB000_0000 | 32'(i);
    end
    @(posedge clk); #1;
    idle_inputs();
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
